// File: rtl/bank_rr_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and one memory bank.
// slave = arbiter side, master = requesters plus bank side.
interface bank_rr_arbiter_if #(
  parameter int REQUESTERS = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [REQUESTERS-1:0]                 req_valid;
  logic [REQUESTERS-1:0]                 req_we;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [REQUESTERS-1:0]                 req_ready;
  logic [REQUESTERS-1:0]                 rsp_valid;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] rsp_data;
  logic                                  m_valid;
  logic                                  m_we;
  logic [ADDR_WIDTH-1:0]                 m_addr;
  logic [DATA_WIDTH-1:0]                 m_wdata;
  logic                                  m_ready;
  logic                                  m_rvalid;
  logic [DATA_WIDTH-1:0]                 m_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, m_ready, m_rvalid, m_rdata,
    output req_ready, rsp_valid, rsp_data, m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, m_ready, m_rvalid, m_rdata,
    input  req_ready, rsp_valid, rsp_data, m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter sharing one bank port among several requesters; an ID FIFO
// remembers who issued each outstanding read so in-order bank data can be routed back.
module bank_rr_arbiter #(
  parameter int REQUESTERS  = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  bank_rr_arbiter_if.slave             bus,
  output logic [$clog2(OUTSTANDING):0] rd_inflight,
  output logic                         err_orphan
);
  localparam int ID_W  = $clog2(REQUESTERS);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  id_mem [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_orphan_reg;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  can_push;
  logic [REQUESTERS-1:0] eligible;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic                  handshake;
  logic                  push;
  logic                  pop_any;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  orphan;
  logic [ID_W-1:0]       head_id;

  assign fifo_empty = (cnt_reg == '0);
  assign fifo_full  = (cnt_reg == CNT_W'(OUTSTANDING));
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign can_push   = ~fifo_full | bus.m_rvalid;

  // Everything combinational is gated by rst so outputs are silent during reset.
  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_elig
      assign eligible[gi] = rst & bus.req_valid[gi] & (bus.req_we[gi] | can_push);
    end
  endgenerate

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= REQUESTERS) begin
        idx = idx - REQUESTERS;
      end
      if (!grant_found && eligible[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  assign handshake   = grant_found & bus.m_ready;
  assign bus.m_valid = grant_found;
  assign bus.m_we    = grant_found & bus.req_we[grant_id];
  assign bus.m_addr  = grant_found ? bus.req_addr[grant_id]  : '0;
  assign bus.m_wdata = grant_found ? bus.req_wdata[grant_id] : '0;

  assign push    = handshake & ~bus.req_we[grant_id];
  assign pop_any = rst & bus.m_rvalid & (~fifo_empty | push);
  // On an empty FIFO a same-cycle read is popped straight through without storage.
  assign head_id = fifo_empty ? grant_id : id_mem[rd_ptr_reg];
  assign fifo_wr = push & ~(pop_any & fifo_empty);
  assign fifo_rd = pop_any & ~fifo_empty;
  assign orphan  = rst & bus.m_rvalid & fifo_empty & ~push;

  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_port
      assign bus.req_ready[gi] = handshake & (grant_id == ID_W'(gi));
      assign bus.rsp_valid[gi] = pop_any & (head_id == ID_W'(gi));
      assign bus.rsp_data[gi]  = bus.rsp_valid[gi] ? bus.m_rdata : '0;
    end
  endgenerate

  assign ptr_next    = (grant_id == ID_W'(REQUESTERS - 1)) ? '0 : grant_id + ID_W'(1);
  assign wr_ptr_next = (wr_ptr_reg == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
  assign rd_ptr_next = (rd_ptr_reg == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (handshake) begin
        ptr_reg <= ptr_next;
      end
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_next;
      end
      if (fifo_rd) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      if (fifo_wr && !fifo_rd) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (!fifo_wr && fifo_rd) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (orphan) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      id_mem[wr_ptr_reg] <= grant_id;
    end
  end

  assign rd_inflight = cnt_reg;
  assign err_orphan  = err_orphan_reg;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Directed bench for bank_rr_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_bank_rr_arbiter;
  localparam int R  = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bank_rr_arbiter_if #(.REQUESTERS(R), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [2:0] rd_inflight;
  logic       err_orphan;

  bank_rr_arbiter #(
    .REQUESTERS(R), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_inflight(rd_inflight), .err_orphan(err_orphan)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pat(input logic [3:0] a);
    return {28'hDA7A000, a};
  endfunction

  // Bank stimulus: either a latency-1 responder or directly driven values.
  logic        bank_auto  = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata  = '0;

  initial begin
    logic       hs_rd;
    logic [3:0] hs_addr;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
    forever begin
      @(negedge clk);
      hs_rd   = bus.m_valid & bus.m_ready & ~bus.m_we;
      hs_addr = bus.m_addr;
      @(posedge clk);
      #2;
      bus.m_rvalid = bank_auto ? hs_rd : man_rvalid;
      bus.m_rdata  = bank_auto ? (hs_rd ? pat(hs_addr) : 32'd0) : man_rdata;
    end
  end

  // Reference model: ptr as an integer, outstanding read IDs as a queue.
  initial begin
    int mptr, nptr, g, h;
    int q[$];
    int nq[$];
    bit morph, norph, can_push, hs;
    logic        e_mvalid, e_we;
    logic [3:0]  e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_rr, e_rsp;
    logic [31:0] e_data [R];
    mptr  = 0;
    morph = 0;
    forever begin
      @(negedge clk);
      e_mvalid = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rr = 0; e_rsp = 0;
      for (int i = 0; i < R; i++) e_data[i] = 0;
      if (!rst) begin
        q.delete();
        mptr = 0; morph = 0;
        nq.delete();
        nptr = 0; norph = 0;
      end else begin
        can_push = (q.size() < OS) || bus.m_rvalid;
        g = -1;
        for (int k = 0; k < R; k++) begin
          if (g < 0 && bus.req_valid[(mptr + k) % R] && (bus.req_we[(mptr + k) % R] || can_push))
            g = (mptr + k) % R;
        end
        nq = q;
        norph = morph;
        nptr = mptr;
        hs = 0;
        if (g >= 0) begin
          e_mvalid = 1;
          e_we     = bus.req_we[g];
          e_addr   = bus.req_addr[g];
          e_wdata  = bus.req_wdata[g];
          hs       = bus.m_ready;
        end
        if (hs) begin
          e_rr[g] = 1'b1;
          nptr = (g + 1) % R;
          if (!e_we) nq.push_back(g);
        end
        if (bus.m_rvalid) begin
          if (nq.size() > 0) begin
            h = nq.pop_front();
            e_rsp[h]  = 1'b1;
            e_data[h] = bus.m_rdata;
          end else begin
            norph = 1;
          end
        end
      end
      check("m_valid", bus.m_valid, e_mvalid);
      check("m_we", bus.m_we, e_we);
      check("m_addr", bus.m_addr, e_addr);
      check("m_wdata", bus.m_wdata, e_wdata);
      check("req_ready", bus.req_ready, e_rr);
      check("rsp_valid", bus.rsp_valid, e_rsp);
      for (int i = 0; i < R; i++) check("rsp_data", bus.rsp_data[i], e_data[i]);
      check("rd_inflight", rd_inflight, 64'(q.size()));
      check("err_orphan", err_orphan, morph);
      @(posedge clk);
      mptr  = nptr;
      q     = nq;
      morph = norph;
    end
  end

  task automatic cyc(input logic rs, input logic [2:0] v, input logic [2:0] we,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst           = rs;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.m_ready   = rdy;
    man_rvalid    = rv;
    man_rdata     = rd;
    @(negedge clk);
  endtask

  initial begin
    int g3 [8];
    int heads [4];
    g3    = '{0, 1, 2, 0, 1, 2, 1, 1};
    heads = '{2, 0, 2, 2};
    bus.req_valid = 3'b111;
    bus.req_we    = 3'b000;
    bus.m_ready   = 1'b1;
    for (int i = 0; i < R; i++) begin
      bus.req_addr[i]  = AW'(i + 1);
      bus.req_wdata[i] = 32'h1111_1111 * (i + 1);
    end

    // reset holds everything quiet even with requests pending
    @(negedge clk);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 3'b000);
    check("rst_inflight", rd_inflight, 3'd0);
    check("rst_orphan", err_orphan, 1'b0);

    // continuous reads, bank latency 1
    bank_auto = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 3'b111, 3'b000, 1, 0, 0);
      check("t1_grant", bus.req_ready, 64'(1) << (k % 3));
      $display("t1 cycle %0d req_ready=%b rsp_valid=%b", k, bus.req_ready, bus.rsp_valid);
      if (k > 0) begin
        check("t1_rsp", bus.rsp_valid, 64'(1) << ((k - 1) % 3));
        check("t1_rdata", bus.rsp_data[(k - 1) % 3], pat(4'((k - 1) % 3 + 1)));
      end
    end
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t1_last_rsp", bus.rsp_valid, 3'b100);
    check("t1_last_data", bus.rsp_data[2], pat(4'd3));
    check("t1_inflight", rd_inflight, 3'd1);
    bank_auto = 1'b0;
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t1_drained", rd_inflight, 3'd0);

    // stalled write keeps its grant
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3'b010, 3'b010, 0, 0, 0);
      check("t2_stall_ready", bus.req_ready, 3'b000);
      check("t2_stall_addr", bus.m_addr, 4'd2);
    end
    cyc(1, 3'b010, 3'b010, 1, 0, 0);
    check("t2_accept", bus.req_ready, 3'b010);
    cyc(1, 3'b111, 3'b111, 1, 0, 0);
    check("t2_ptr2", bus.req_ready, 3'b100);
    $display("t2 done req_ready=%b", bus.req_ready);

    // fill the ID FIFO; writes keep flowing past blocked reads
    for (int k = 0; k < 8; k++) begin
      cyc(1, 3'b111, 3'b010, 1, 0, 0);
      check("t3_grant", bus.req_ready, 64'(1) << g3[k]);
      if (k >= 6) check("t3_full", rd_inflight, 3'd4);
    end
    cyc(1, 3'b111, 3'b010, 1, 1, 32'hBEEF_0001);
    check("t3_pushpop_grant", bus.req_ready, 3'b100);
    check("t3_pushpop_rsp", bus.rsp_valid, 3'b001);
    check("t3_pushpop_data", bus.rsp_data[0], 32'hBEEF_0001);
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t3_still_full", rd_inflight, 3'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 3'b000, 3'b000, 1, 1, 32'hBEEF_0010 + k);
      check("t3_drain", bus.rsp_valid, 64'(1) << heads[k]);
      $display("t3 drain %0d rsp_valid=%b", k, bus.rsp_valid);
    end
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t3_empty", rd_inflight, 3'd0);

    // bypass at empty
    cyc(1, 3'b100, 3'b000, 1, 1, 32'hCAFE_F00D);
    check("t4_grant", bus.req_ready, 3'b100);
    check("t4_rsp", bus.rsp_valid, 3'b100);
    check("t4_data", bus.rsp_data[2], 32'hCAFE_F00D);
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t4_inflight", rd_inflight, 3'd0);
    check("t4_no_orphan", err_orphan, 1'b0);

    // orphan response
    cyc(1, 3'b000, 3'b000, 1, 1, 32'h0000_0BAD);
    check("t5_no_rsp", bus.rsp_valid, 3'b000);
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t5_orphan", err_orphan, 1'b1);
    cyc(1, 3'b000, 3'b000, 1, 0, 0);
    check("t5_sticky", err_orphan, 1'b1);

    // reset with reads in flight
    cyc(1, 3'b110, 3'b000, 1, 0, 0);
    check("t6_g1", bus.req_ready, 3'b010);
    cyc(1, 3'b110, 3'b000, 1, 0, 0);
    check("t6_g2", bus.req_ready, 3'b100);
    cyc(1, 3'b110, 3'b000, 1, 0, 0);
    check("t6_g3", bus.req_ready, 3'b010);
    cyc(0, 3'b111, 3'b000, 1, 1, 32'h5555_5555);
    check("t6_rst_inflight", rd_inflight, 3'd0);
    check("t6_rst_m_valid", bus.m_valid, 1'b0);
    check("t6_rst_ready", bus.req_ready, 3'b000);
    check("t6_rst_rsp", bus.rsp_valid, 3'b000);
    check("t6_rst_orphan", err_orphan, 1'b0);
    cyc(1, 3'b000, 3'b000, 1, 1, 32'h6666_6666);
    check("t6_late_rsp", bus.rsp_valid, 3'b000);
    cyc(1, 3'b111, 3'b000, 1, 0, 0);
    check("t6_first_grant", bus.req_ready, 3'b001);
    check("t6_late_orphan", err_orphan, 1'b1);
    cyc(1, 3'b000, 3'b000, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
